// File: rtl/entropy_collector.sv
// entropy_collector: NUM_OSC oscillators XOR-folded into 16-bit words, repetition-checked,
// FIFO-buffered and read over cs/we/addr. Macro ENTROPY_COLLECTOR_DEBUG_EN selects RAW-latching debug.
`default_nettype none

module entropy_collector_rosc #(
  parameter int ROT = 0
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic [7:0] opa_i,
  input  logic [7:0] opb_i,
  output logic       dout_o
);
  logic [7:0] opa_rot;
  logic [8:0] sum;
  logic       dout_q;

  // Carry-out fed back inverted: oscillates when opa+opb sits on the carry boundary.
  assign opa_rot = (opa_i << ROT) | (opa_i >> (8 - ROT));
  assign sum     = {1'b0, opa_rot} + {1'b0, opb_i} + {8'h00, ~dout_q};
  assign dout_o  = dout_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) dout_q <= 1'b0;
    else         dout_q <= sum[8];
  end
endmodule

module entropy_collector #(
  parameter int          NUM_OSC       = 32,
  parameter int          SAMPLE_CYCLES = 16,
  parameter int          FIFO_DEPTH    = 8,
  parameter int          REP_LIMIT     = 4,
  parameter logic [31:0] DEBUG_DELAY   = 32'h004c4b40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] dwrite,
  output logic [15:0] dread,
  output logic [7:0]  debug
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int RW  = $clog2(REP_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CHECK   = 3'd2,
    PUSH    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t          state_q;
  logic            enable_q;
  logic [7:0]      opa_q, opb_q;
  logic [15:0]     acc_q, last_word_q;
  logic [4:0]      bitcnt_q;
  logic [RW-1:0]   rep_q, rep_next;
  logic            error_q;
  logic [SCW-1:0]  scnt_q;
  logic [7:0]      debug_q;

  logic [15:0]     fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [8:0]      count_ext;

  logic [NUM_OSC-1:0] osc;
  logic            osc_fold;
  logic [15:0]     raw;
  logic            wr_en, rd_en, ctrl_wr, flush, clr_err;
  logic            empty, full, pop, push, strobe;

  genvar i;
  generate
    for (i = 0; i < NUM_OSC; i++) begin : g_osc
      entropy_collector_rosc #(.ROT(i % 8)) u_rosc (
        .clk    (clk),
        .rst_ni (~reset),
        .opa_i  (opa_q),
        .opb_i  (opb_q),
        .dout_o (osc[i])
      );
    end
  endgenerate

  assign osc_fold  = ^osc;
  assign raw       = 16'(osc);

  assign wr_en     = cs & we;
  assign rd_en     = cs & ~we;
  assign ctrl_wr   = wr_en & (addr == 8'h00);
  assign flush     = ctrl_wr & dwrite[1];
  assign clr_err   = ctrl_wr & dwrite[2];

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign count_ext = 9'(count_q);
  assign pop       = rd_en & (addr == 8'h11) & ~empty;
  // A full FIFO still accepts the stalled word when the head leaves in the same cycle.
  assign push      = (state_q == PUSH) & (~full | pop) & ~flush;
  assign strobe    = (state_q == COLLECT) & (scnt_q == SCW'(SAMPLE_CYCLES - 1));
  assign rep_next  = (acc_q == last_word_q) ? rep_q + RW'(1) : RW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    scnt_q <= '0;
    else if (state_q != COLLECT)  scnt_q <= '0;
    else if (strobe)              scnt_q <= '0;
    else                          scnt_q <= scnt_q + SCW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      opa_q       <= 8'h55;
      opb_q       <= 8'haa;
      acc_q       <= 16'h0000;
      last_word_q <= 16'h0000;
      bitcnt_q    <= 5'd0;
      rep_q       <= '0;
      error_q     <= 1'b0;
    end else begin
      if (ctrl_wr)                       enable_q <= dwrite[0];
      if (wr_en && (addr == 8'h01))      opa_q    <= dwrite[7:0];
      if (wr_en && (addr == 8'h02))      opb_q    <= dwrite[7:0];

      case (state_q)
        IDLE: if (enable_q) state_q <= COLLECT;
        COLLECT: begin
          if (!enable_q) begin
            state_q <= IDLE;
          end else if (strobe && !flush) begin
            acc_q    <= {acc_q[14:0], osc_fold};
            bitcnt_q <= bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd15) state_q <= CHECK;
          end
        end
        CHECK: begin
          last_word_q <= acc_q;
          rep_q       <= rep_next;
          if (rep_next == RW'(REP_LIMIT)) begin
            error_q  <= 1'b1;
            bitcnt_q <= 5'd0;
            state_q  <= ERROR;
          end else begin
            state_q  <= PUSH;
          end
        end
        PUSH: begin
          if (push) begin
            bitcnt_q <= 5'd0;
            state_q  <= enable_q ? COLLECT : IDLE;
          end
        end
        ERROR:   if (clr_err) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // Flush discards the word in flight and restarts assembly from scratch.
      if (flush) begin
        acc_q    <= 16'h0000;
        bitcnt_q <= 5'd0;
        if ((state_q == PUSH) ||
            ((state_q == CHECK) && (rep_next != RW'(REP_LIMIT))))
          state_q <= COLLECT;
      end
      if (clr_err) begin
        error_q <= 1'b0;
        rep_q   <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= acc_q;
  end

  always_comb begin
    dread = 16'h0000;
    if (rd_en) begin
      case (addr)
        8'h10:   dread = {count_ext[7:0], 5'b00000, error_q, full, empty};
        8'h11:   dread = empty ? 16'h0000 : fifo_mem_q[rd_ptr_q];
        8'h12:   dread = raw;
        8'h13:   dread = {opa_q, 5'b00000, enable_q, 2'b00};
        default: dread = 16'h0000;
      endcase
    end
  end

`ifdef ENTROPY_COLLECTOR_DEBUG_EN
  logic [31:0] dbg_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_cnt_q <= 32'd0;
      debug_q   <= 8'h00;
    end else begin
      dbg_cnt_q <= (dbg_cnt_q == DEBUG_DELAY) ? 32'd0 : dbg_cnt_q + 32'd1;
      if (dbg_cnt_q == 32'd0) debug_q <= raw[7:0];
    end
  end
`else
  logic unused_delay;
  assign unused_delay = ^DEBUG_DELAY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) debug_q <= 8'h00;
    else       debug_q <= {error_q, full, empty, 2'b00, state_q};
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{dwrite[15:8], count_ext[8]};
  assign debug       = debug_q;

endmodule

`default_nettype wire
